// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO read/write side logic:
// scheduler state encoding, default burst-length width and id-width helper.
package fifo_pkg;

  localparam int unsigned LEN_W_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_LAST  = 2'd2;

  // Width of an encoded requester index; at least one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past i_ptr and wraps.
// Shared by the read and write side schedulers.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [id_w(NREQ)-1:0]   i_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic [id_w(NREQ)-1:0]   o_id
);

  localparam int unsigned IDW = id_w(NREQ);

  logic           w_found;
  logic [IDW-1:0] w_idx;

  // First requester found after the pointer, in wrap-around order.
  always_comb begin
    o_gnt   = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_idx = IDW'((32'(i_ptr) + i) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_scheduler.sv
// Read-side scheduler for the async FIFO (Rclk domain). Grants one burst at a
// time in round-robin order, drives Rinc and returns popped words tagged with
// the requester id. Optional stall timeout: FIFO_RD_SCHED_TIMEOUT_EN.
module fifo_rd_scheduler
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = LEN_W_DEF
`ifdef FIFO_RD_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = 15
`endif
) (
  input  logic                    Rclk,
  input  logic                    Rrst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  input  logic                    Rempty,
  input  logic [DATA_WIDTH-1:0]   Rdata,
  output logic                    Rinc,
  output logic [NREQ-1:0]         grant,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [id_w(NREQ)-1:0]   out_id,
  output logic                    out_last,
  output logic [NREQ-1:0]         done,
  output logic                    abort
);

  localparam int unsigned IDW   = id_w(NREQ);
  localparam int unsigned CNT_W = LEN_W + 1;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [IDW-1:0]        r_ptr;
  logic [IDW-1:0]        r_id;
  logic [NREQ-1:0]       r_grant;
  logic [CNT_W-1:0]      r_count;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [IDW-1:0]        r_out_id;
  logic                  r_out_last;
  logic [NREQ-1:0]       r_done;

  logic [NREQ-1:0]       w_arb_gnt;
  logic [IDW-1:0]        w_arb_id;
  logic [LEN_W-1:0]      w_len;
  logic [CNT_W-1:0]      w_len_ld;
  logic                  w_pop;
  logic                  w_last_pop;
  logic                  w_timeout;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_id  (w_arb_id)
  );

  // Length of the winning requester; zero means a full 2^LEN_W burst.
  assign w_len      = req_len[32'(w_arb_id)*LEN_W +: LEN_W];
  assign w_len_ld   = (w_len == '0) ? CNT_W'(1 << LEN_W) : {1'b0, w_len};
  assign w_pop      = (r_state == ST_BURST) && !Rempty;
  assign w_last_pop = w_pop && (r_count == CNT_W'(1));

  assign Rinc      = w_pop;
  assign grant     = r_grant;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_last  = r_out_last;
  assign done      = r_done;

`ifdef FIFO_RD_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_stall;
  logic          r_abort;

  assign w_timeout = (r_state == ST_BURST) && Rempty && (r_stall == TW'(TIMEOUT - 1));
  assign abort     = r_abort;

  // Consecutive empty cycles within a burst; any pop or state change clears it.
  always_ff @(posedge Rclk or negedge Rrst) begin
    if (!Rrst) begin
      r_stall <= '0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_timeout;
      if ((r_state == ST_BURST) && Rempty && !w_timeout) r_stall <= r_stall + TW'(1);
      else                                               r_stall <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign abort     = 1'b0;
`endif

  // State register.
  always_ff @(posedge Rclk or negedge Rrst) begin
    if (!Rrst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (|req) w_state_nxt = ST_BURST;
      ST_BURST: if (w_last_pop || w_timeout) w_state_nxt = ST_LAST;
      ST_LAST:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant/count bookkeeping and registered output word.
  always_ff @(posedge Rclk or negedge Rrst) begin
    if (!Rrst) begin
      r_ptr       <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_grant     <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_out_last  <= 1'b0;
      r_done      <= '0;
    end else begin
      r_out_valid <= w_pop;
      r_out_last  <= w_last_pop;
      r_done      <= '0;
      if (w_pop) begin
        r_out_data <= Rdata;
        r_out_id   <= r_id;
        if (!w_last_pop) r_count <= r_count - CNT_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_grant <= w_arb_gnt;
            r_id    <= w_arb_id;
            r_count <= w_len_ld;
          end
        end
        ST_BURST: if (w_last_pop || w_timeout) r_done <= r_grant;
        ST_LAST: begin
          r_grant <= '0;
          r_ptr   <= r_id;
        end
        default: r_grant <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// Bench for fifo_rd_scheduler: behavioural FIFO model, output scoreboard,
// round-robin vector table and hand-written burst/stall/reset sequences.
// Define FIFO_RD_SCHED_TIMEOUT_EN to exercise the stall timeout.
module tb_fifo_rd_scheduler;

  logic        Rclk = 1'b0;
  logic        Rrst;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic        Rempty = 1'b1;
  logic [7:0]  Rdata  = 8'h00;
  logic        Rinc;
  logic [3:0]  grant;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_last;
  logic [3:0]  done;
  logic        abort;

  fifo_rd_scheduler #(.NREQ(4), .DATA_WIDTH(8), .LEN_W(4)) dut (
    .Rclk      (Rclk),
    .Rrst      (Rrst),
    .req       (req),
    .req_len   (req_len),
    .Rempty    (Rempty),
    .Rdata     (Rdata),
    .Rinc      (Rinc),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .done      (done),
    .abort     (abort)
  );

  always #5 Rclk = ~Rclk;

  typedef struct { logic [7:0] data; logic [1:0] id; logic last; } exp_t;
  typedef struct { logic [3:0] req; logic [3:0] gnt; } rr_vec_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] fifo_q[$];
  logic [7:0] wr_q[$];
  logic       pop_pend = 1'b0;
  logic       fifo_rst_ok;
  int         checks = 0;
  int         errors = 0;
  int         n_out  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh2id(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic tick();
    @(negedge Rclk);
    #1;
  endtask

  task automatic exp_push(input logic [7:0] d, input logic [1:0] id, input logic last);
    exp_t e;
    e.data = d; e.id = id; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input logic [3:0] exp, input string name);
    int n;
    n = 0;
    while (grant == 4'b0 && n < 8) begin tick(); n++; end
    chk(name, grant, exp);
  endtask

  task automatic wait_done(input logic [3:0] exp_done, input logic exp_last,
                           input logic exp_abort, input int budget, input string name);
    int n;
    n = 0;
    while (done == 4'b0 && n < budget) begin tick(); n++; end
    chk({name, "_done"}, done, exp_done);
    chk({name, "_last"}, out_last, exp_last);
    chk({name, "_abort"}, abort, exp_abort);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_rinc"}, Rinc, 0);
    chk({name, "_grant"}, grant, 0);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_data"}, out_data, 0);
    chk({name, "_id"}, out_id, 0);
    chk({name, "_last"}, out_last, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_abort"}, abort, 0);
  endtask

  // FIFO read-side model: pop decided mid-cycle, applied after the clock edge.
  always @(posedge Rclk) begin
    fifo_rst_ok = Rrst;
    #1;
    if (fifo_rst_ok && pop_pend && fifo_q.size() > 0) fifo_q.delete(0);
    while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
    Rempty = (fifo_q.size() == 0);
    Rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  // Mid-cycle monitor: protocol check and scoreboard comparison.
  always @(negedge Rclk) begin
    pop_pend = Rinc;
    chk("rinc_while_empty", Rinc & Rempty, 0);
    if (out_valid) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: data 0x%0h id %0d with no word expected", out_data, out_id);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", out_data, mon_e.data);
        chk("out_id", out_id, mon_e.id);
        chk("out_last", out_last, mon_e.last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rr_vec_t tbl[11];
    int      n;
    int      pops;
    int      hits;
    int      base;

    tbl[0]  = '{req: 4'b1111, gnt: 4'b0001};
    tbl[1]  = '{req: 4'b1111, gnt: 4'b0010};
    tbl[2]  = '{req: 4'b1111, gnt: 4'b0100};
    tbl[3]  = '{req: 4'b1111, gnt: 4'b1000};
    tbl[4]  = '{req: 4'b1111, gnt: 4'b0001};
    tbl[5]  = '{req: 4'b1010, gnt: 4'b0010};
    tbl[6]  = '{req: 4'b1010, gnt: 4'b1000};
    tbl[7]  = '{req: 4'b0101, gnt: 4'b0001};
    tbl[8]  = '{req: 4'b0100, gnt: 4'b0100};
    tbl[9]  = '{req: 4'b0110, gnt: 4'b0010};
    tbl[10] = '{req: 4'b1000, gnt: 4'b1000};

    req = 4'b0; req_len = 16'h0; Rrst = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    Rrst = 1'b1;
    tick();

    // Round-robin table, single-word bursts back to back.
    req_len = 16'h1111;
    for (int i = 0; i < 11; i++) begin
      wr_q.push_back(8'(8'h80 + i));
      exp_push(8'(8'h80 + i), oh2id(tbl[i].gnt), 1'b1);
    end
    tick(); tick();
    req = tbl[0].req;
    for (int i = 0; i < 11; i++) begin
      if (i == 0) wait_grant(tbl[0].gnt, "rr_grant");
      else begin
        chk("rr_idle_gap", grant, 0);
        tick();
        chk("rr_grant", grant, tbl[i].gnt);
      end
      chk("rr_rinc", Rinc, 1);
      tick();
      chk("rr_done", done, tbl[i].gnt);
      chk("rr_rinc_off", Rinc, 0);
      req = (i < 10) ? tbl[i+1].req : 4'b0;
      tick();
    end

    // Single 4-word burst for requester 0.
    req_len = 16'h0004;
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back(8'(8'h11 + i));
      exp_push(8'(8'h11 + i), 2'd0, i == 3);
    end
    tick(); tick();
    req = 4'b0001;
    wait_grant(4'b0001, "single_grant");
    for (int k = 0; k < 4; k++) begin
      chk("single_rinc", Rinc, 1);
      tick();
    end
    chk("single_done", done, 4'b0001);
    chk("single_last", out_last, 1);
    chk("single_rinc_off", Rinc, 0);
    req = 4'b0;
    tick();
    chk("single_grant_clear", grant, 0);

    // Empty stall: one word, the rest arrive later.
    req_len = 16'h0030;
    wr_q.push_back(8'h31);
    exp_push(8'h31, 2'd1, 1'b0);
    exp_push(8'h32, 2'd1, 1'b0);
    exp_push(8'h33, 2'd1, 1'b1);
    tick(); tick();
    req = 4'b0010;
    wait_grant(4'b0010, "stall_grant");
    chk("stall_rinc_first", Rinc, 1);
    tick();
    for (int k = 0; k < 9; k++) begin
      chk("stall_rinc", Rinc, 0);
      chk("stall_valid", out_valid, (k == 0) ? 1 : 0);
      tick();
    end
    wr_q.push_back(8'h32);
    wr_q.push_back(8'h33);
    wait_done(4'b0010, 1'b1, 1'b0, 20, "stall");
    req = 4'b0;
    tick();

    // Length 0 means 16 words; one extra word must stay in the FIFO.
    req_len = 16'h0000;
    for (int i = 0; i < 17; i++) wr_q.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 16; i++) exp_push(8'(8'hA0 + i), 2'd2, i == 15);
    tick(); tick();
    req = 4'b0100;
    wait_grant(4'b0100, "len0_grant");
    pops = 0; n = 0;
    while (done == 4'b0 && n < 40) begin
      if (Rinc) pops++;
      tick(); n++;
    end
    chk("len0_pops", pops, 16);
    chk("len0_done", done, 4'b0100);
    chk("len0_last", out_last, 1);
    req = 4'b0;
    tick();
    chk("len0_left", fifo_q.size(), 1);
    fifo_q.delete();
    tick(); tick();

    // Reset after two of five pops; pointer must return to its reset value.
    req_len = 16'h0005;
    for (int i = 0; i < 5; i++) wr_q.push_back(8'(8'h51 + i));
    exp_push(8'h51, 2'd0, 1'b0);
    exp_push(8'h52, 2'd0, 1'b0);
    tick(); tick();
    base = n_out; n = 0;
    req = 4'b0001;
    while (n_out < base + 2 && n < 20) begin tick(); n++; end
    chk("rst_two_pops", n_out - base, 2);
    Rrst = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    chk("midrst_no_done", done, 0);
    exp_push(8'h53, 2'd0, 1'b1);
    req_len = 16'h1111;
    req = 4'b1111;
    Rrst = 1'b1;
    wait_grant(4'b0001, "post_reset_grant");
    wait_done(4'b0001, 1'b1, 1'b0, 6, "post_reset");
    req = 4'b0;
    tick();
    fifo_q.delete();
    tick(); tick();

`ifdef FIFO_RD_SCHED_TIMEOUT_EN
    // Timeout: two words of a four-word burst, then 15 empty cycles.
    req_len = 16'h4000;
    wr_q.push_back(8'h61);
    wr_q.push_back(8'h62);
    exp_push(8'h61, 2'd3, 1'b0);
    exp_push(8'h62, 2'd3, 1'b0);
    tick(); tick();
    req = 4'b1000;
    wait_grant(4'b1000, "to_grant");
    hits = 0; n = 0;
    while (done == 4'b0 && n < 60) begin
      if (Rempty && grant != 4'b0) hits++;
      tick(); n++;
    end
    chk("to_empty_cycles", hits, 15);
    chk("to_done", done, 4'b1000);
    chk("to_abort", abort, 1);
    chk("to_no_last", out_last, 0);
    req = 4'b0;
    tick();
    chk("to_abort_pulse", abort, 0);
    chk("to_grant_clear", grant, 0);
`else
    // Without timeout a starved burst waits well past 15 cycles.
    req_len = 16'h2000;
    wr_q.push_back(8'h61);
    exp_push(8'h61, 2'd3, 1'b0);
    exp_push(8'h62, 2'd3, 1'b1);
    tick(); tick();
    req = 4'b1000;
    wait_grant(4'b1000, "wait_grant");
    hits = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (abort || done != 4'b0) hits++;
    end
    chk("wait_no_end", hits, 0);
    chk("wait_grant_held", grant, 4'b1000);
    wr_q.push_back(8'h62);
    wait_done(4'b1000, 1'b1, 1'b0, 10, "wait");
    req = 4'b0;
    tick();
`endif

    tick(); tick();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_scheduler.md
# fifo_rd_scheduler

Read-side scheduler for the asynchronous FIFO, in the Rclk domain. It shares the FIFO read port among NREQ consumers. Each consumer requests a burst of words; the scheduler grants one requester at a time in round-robin order and drives the FIFO read increment. It returns the popped words tagged with the requester ID.

## Interface
- NREQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, FIFO word width
- LEN_W, 4, burst-length field width; burst length 0 encodes 2^LEN_W words
- TIMEOUT, 15, consecutive empty cycles before abort (only with macro)
- Rclk  in  1  read-domain clock
- Rrst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester burst request, level; held until done
- req_len  in  NREQ*LEN_W  burst length, slice i belongs to requester i; sampled at grant
- Rempty  in  1  FIFO empty flag, registered in Rclk domain
- Rdata  in  DATA_WIDTH  FIFO read data at current read address
- Rinc  out  1  FIFO read increment
- grant  out  NREQ  one-hot owner of current burst, registered
- out_valid  out  1  out_data/out_id hold a popped word
- out_data  out  DATA_WIDTH  popped word
- out_id  out  $clog2(NREQ)  requester index for out_data
- out_last  out  1  final word of burst, qualified by out_valid
- done  out  NREQ  one-cycle pulse to the requester whose burst ended
- abort  out  1  one-cycle pulse, burst ended by timeout (only with macro, else tied 0)

## Operation
- FSM states:
  - IDLE: if any req is high, go to BURST next cycle. Load grant from the round-robin pick. Load count from the granted req_len (0 loads 2^LEN_W).
  - BURST: Rinc = !Rempty (combinational). Each cycle with Rinc=1 pops one word and decrements count. When the pop reaches count==1, go to LAST.
  - LAST: one cycle. Pulse done[id], return to IDLE, update the priority pointer to the just-served id.
- Round-robin: search begins at pointer+1 modulo NREQ. The pointer resets to NREQ-1, so requester 0 wins first.
- Rempty=1 in BURST stalls the burst: Rinc=0, count held, no output.
- Deasserting req mid-burst is ignored; the burst completes.
- The scheduler never asserts Rinc while Rempty=1, and never outside BURST.
- count width is LEN_W+1. Arithmetic never wraps below 1 in BURST.

## Timing
- Reset values: Rinc 0, grant 0, out_valid 0, out_data 0, out_id 0, out_last 0, done 0, abort 0. FSM is IDLE, pointer NREQ-1.
- Reset mid-burst clears everything immediately. The burst is lost and no done is issued.
- Request sampled in cycle N (IDLE): grant valid in cycle N+1, and the earliest Rinc is in N+1.
- Pop in cycle M: out_valid/out_data/out_id registered in cycle M+1. Rdata is captured in cycle M.
- Final pop in cycle M: out_last=1 in M+1. done pulses in M+1 (the LAST state), and grant clears in M+2.
- Minimum gap between bursts is 1 IDLE cycle, so peak throughput is L words per L+2 cycles.

## Configuration
- FIFO_RD_SCHED_TIMEOUT_EN defined:
  - A stall counter counts consecutive BURST cycles with Rempty=1.
  - On reaching TIMEOUT, the FSM goes to LAST. done[id] and abort pulse together, with no out_last. The pointer advances as normal.
  - Any pop clears the stall counter.
- Not defined: no stall counter. Bursts wait indefinitely for data, and abort is tied 0.

## Structure
- Shared package fifo_pkg holds:
  - state encoding constants (IDLE, BURST, LAST)
  - the default LEN_W
  - the id-width function
- Sub-module rr_arbiter (NREQ): inputs req and pointer; outputs one-hot grant and encoded id. It is purely combinational and is also reusable on the write side.

## Test plan
- Single burst, FIFO preloaded with 0x11..0x14: req[0]=1 with len 4 → four consecutive Rinc cycles; out_data 0x11..0x14 with out_id 0; out_last and done[0] on the 4th word.
- Round-robin fairness: req=4'b1111, all with len 1 → grants in order 0,1,2,3,0. Each burst is exactly one Rinc, with a 1-cycle IDLE gap between bursts.
- Empty stall: len 3, FIFO holds 1 word, second word written 10 cycles later → 1 pop, Rinc low while Rempty=1, then the 2nd pop. No spurious out_valid.
- Length 0: req[2] with len 0 and 16 words available → exactly 16 pops; out_last on the 16th.
- Reset mid-burst: Rrst low after 2 of 5 pops → all outputs 0 that cycle, no done. After release, req[0] is granted first.
- Timeout (macro on, TIMEOUT=15): len 4, FIFO holds 2 words → 2 pops; done[id] and abort pulse on the 15th consecutive empty cycle; no out_last.
